cdb_arbiter: RTL and testbench

- Owns the single common data bus (CDB) that broadcasts completed results to the reorder buffer, reservation station and load/store buffer.
- Arbitrates between two producers: the ALU/RS completion port (value plus next_pc) and the LSB load-completion port (value only).
- Each producer has a small FIFO, so neither stalls when the other wins the bus.
- Exactly one result is broadcast per cycle; grants alternate round-robin when both queues are non-empty; all queued results are dropped on a mispredict flush.

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_src_fifo.sv | 59 +++++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source ids and the queued-result bundle for the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int RoB_WIDTH  = 8;
    localparam int DATA_WIDTH = 32;
    localparam int Q_WIDTH    = 2;
    localparam int Q_DEPTH    = 1 << Q_WIDTH;

    localparam logic SRC_RS  = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    // One queued completion: destination RoB tag, result value and next_pc.
    typedef struct packed {
        logic [RoB_WIDTH-1:0]  RoB_index;
        logic [DATA_WIDTH-1:0] value;
        logic [ADDR_WIDTH-1:0] next_pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshakes and the broadcast bus of the common data bus.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                  RSCDB_en;
    logic [RoB_WIDTH-1:0]  RSCDB_RoB_index;
    logic [DATA_WIDTH-1:0] RSCDB_value;
    logic [ADDR_WIDTH-1:0] RSCDB_next_pc;
    logic                  CDBRS_ready;

    logic                  LSBCDB_en;
    logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index;
    logic [DATA_WIDTH-1:0] LSBCDB_value;
    logic                  CDBLSB_ready;

    logic                  CDB_en;
    logic                  CDB_src;
    logic [RoB_WIDTH-1:0]  CDB_RoB_index;
    logic [DATA_WIDTH-1:0] CDB_value;
    logic [ADDR_WIDTH-1:0] CDB_next_pc;

    // Producer / consumer side.
    modport master (
        output RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
        output LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
        input  CDBRS_ready, CDBLSB_ready,
        input  CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc
    );

    // Arbiter side.
    modport slave (
        input  RSCDB_en, RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc,
        input  LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
        output CDBRS_ready, CDBLSB_ready,
        output CDB_en, CDB_src, CDB_RoB_index, CDB_value, CDB_next_pc
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Small circular FIFO holding results of one producer until it wins the bus.
// Flush has priority over push and pop; pushing while full is ignored.
module cdb_src_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_ptr;
    logic [DEPTH_LOG2-1:0] tail_ptr;
    logic                  push_fire;
    logic                  pop_fire;

    assign full      = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push_fire = push && !full && !flush;
    assign pop_fire  = pop && !empty && !flush;
    assign head_data = mem[head_ptr];

    // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_fire) tail_ptr <= tail_ptr + DEPTH_LOG2'(1);
            if (pop_fire)  head_ptr <= head_ptr + DEPTH_LOG2'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is written only on an accepted push and needs no reset.
    always_ff @(posedge clk) begin
        if (push_fire) mem[tail_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU/RS and LSB completions and broadcasts
// one per cycle, alternating between the two sources when both are waiting.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic            Sys_clk,
    input  logic            Sys_rst,
    input  logic            Sys_rdy,
    input  logic            RoBCDB_pre_judge,
    cdb_arbiter_if.slave    cdb
);

    cdb_entry_t      rs_in;
    cdb_entry_t      lsb_in;
    cdb_entry_t      rs_head;
    cdb_entry_t      lsb_head;
    cdb_entry_t      win_entry;
    logic [Q_WIDTH:0] rs_count;
    logic [Q_WIDTH:0] lsb_count;
    logic            rs_full;
    logic            rs_empty;
    logic            lsb_full;
    logic            lsb_empty;
    logic            flush;
    logic            advance;
    logic            rs_push;
    logic            lsb_push;
    logic            rs_pop;
    logic            lsb_pop;
    logic            grant_valid;
    logic            grant_src;
    logic            last_grant;

    logic                  cdb_en_q;
    logic                  cdb_src_q;
    logic [RoB_WIDTH-1:0]  cdb_idx_q;
    logic [DATA_WIDTH-1:0] cdb_value_q;
    logic [ADDR_WIDTH-1:0] cdb_pc_q;

    // A mispredict wipes the queues; otherwise work only while the core is enabled.
    assign flush   = !RoBCDB_pre_judge;
    assign advance = Sys_rdy && RoBCDB_pre_judge;

    // Ready is taken from the pre-edge occupancy, so a full queue being popped still reads not-ready.
    assign cdb.CDBRS_ready  = (rs_count  != (Q_WIDTH+1)'(Q_DEPTH));
    assign cdb.CDBLSB_ready = (lsb_count != (Q_WIDTH+1)'(Q_DEPTH));

    assign rs_push  = cdb.RSCDB_en  && !rs_full  && advance;
    assign lsb_push = cdb.LSBCDB_en && !lsb_full && advance;

    assign rs_in  = '{RoB_index: cdb.RSCDB_RoB_index,
                      value:     cdb.RSCDB_value,
                      next_pc:   cdb.RSCDB_next_pc};
    assign lsb_in = '{RoB_index: cdb.LSBCDB_RoB_index,
                      value:     cdb.LSBCDB_value,
                      next_pc:   '0};

    cdb_src_fifo #(.DEPTH_LOG2(Q_WIDTH), .WIDTH($bits(cdb_entry_t))) u_rs_fifo (
        .clk       (Sys_clk),
        .rst_n     (Sys_rst),
        .flush     (flush),
        .push      (rs_push),
        .push_data (rs_in),
        .pop       (rs_pop),
        .head_data (rs_head),
        .count     (rs_count),
        .full      (rs_full),
        .empty     (rs_empty)
    );

    cdb_src_fifo #(.DEPTH_LOG2(Q_WIDTH), .WIDTH($bits(cdb_entry_t))) u_lsb_fifo (
        .clk       (Sys_clk),
        .rst_n     (Sys_rst),
        .flush     (flush),
        .push      (lsb_push),
        .push_data (lsb_in),
        .pop       (lsb_pop),
        .head_data (lsb_head),
        .count     (lsb_count),
        .full      (lsb_full),
        .empty     (lsb_empty)
    );

    // Round-robin choice: a lone waiting source wins, on a tie the one not granted last.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_RS;
        if (!rs_empty && !lsb_empty) begin
            grant_valid = 1'b1;
            grant_src   = (last_grant == SRC_RS) ? SRC_LSB : SRC_RS;
        end else if (!rs_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_RS;
        end else if (!lsb_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSB;
        end
    end

    assign rs_pop    = advance && grant_valid && (grant_src == SRC_RS);
    assign lsb_pop   = advance && grant_valid && (grant_src == SRC_LSB);
    assign win_entry = (grant_src == SRC_LSB) ? lsb_head : rs_head;

    // Broadcast register: loads the winner, idles on empty, clears valid on flush, freezes when disabled.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            cdb_en_q    <= 1'b0;
            cdb_src_q   <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_value_q <= '0;
            cdb_pc_q    <= '0;
            last_grant  <= SRC_LSB;
        end else if (flush) begin
            cdb_en_q <= 1'b0;
        end else if (Sys_rdy) begin
            if (grant_valid) begin
                cdb_en_q    <= 1'b1;
                cdb_src_q   <= grant_src;
                cdb_idx_q   <= win_entry.RoB_index;
                cdb_value_q <= win_entry.value;
                cdb_pc_q    <= win_entry.next_pc;
                last_grant  <= grant_src;
            end else begin
                cdb_en_q <= 1'b0;
            end
        end
    end

    assign cdb.CDB_en        = cdb_en_q;
    assign cdb.CDB_src       = cdb_src_q;
    assign cdb.CDB_RoB_index = cdb_idx_q;
    assign cdb.CDB_value     = cdb_value_q;
    assign cdb.CDB_next_pc   = cdb_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expected broadcasts.
module tb_cdb_arbiter;

    logic Sys_clk;
    logic Sys_rst;
    logic Sys_rdy;
    logic RoBCDB_pre_judge;

    int num_checks = 0;
    int num_fail   = 0;

    int   rs_sent, lsb_sent, got;
    int   rs_run, lsb_run, rs_max_run, lsb_max_run, rs_drops, lsb_drops;
    logic rs_go, lsb_go;
    logic exp_src;
    int   exp_idx;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .Sys_clk          (Sys_clk),
        .Sys_rst          (Sys_rst),
        .Sys_rdy          (Sys_rdy),
        .RoBCDB_pre_judge (RoBCDB_pre_judge),
        .cdb              (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        Sys_clk = 1'b0;
        forever #5 Sys_clk = ~Sys_clk;
    end

    // Producers must never offer a result to a full queue.
    always @(posedge Sys_clk) begin
        if (Sys_rst && bus.RSCDB_en) begin
            num_checks++;
            assert (bus.CDBRS_ready === 1'b1) else begin
                num_fail++;
                $error("[TB] FAIL rs_protocol: ready observed %0b required 1", bus.CDBRS_ready);
            end
        end
        if (Sys_rst && bus.LSBCDB_en) begin
            num_checks++;
            assert (bus.CDBLSB_ready === 1'b1) else begin
                num_fail++;
                $error("[TB] FAIL lsb_protocol: ready observed %0b required 1", bus.CDBLSB_ready);
            end
        end
    end

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rs_en, input logic [7:0] rs_idx,
                                 input logic [31:0] rs_val, input logic [31:0] rs_pc,
                                 input logic lsb_en, input logic [7:0] lsb_idx,
                                 input logic [31:0] lsb_val);
        bus.RSCDB_en         = rs_en;
        bus.RSCDB_RoB_index  = rs_idx;
        bus.RSCDB_value      = rs_val;
        bus.RSCDB_next_pc    = rs_pc;
        bus.LSBCDB_en        = lsb_en;
        bus.LSBCDB_RoB_index = lsb_idx;
        bus.LSBCDB_value     = lsb_val;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        assert (observed === expected) else begin
            num_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic en, input logic src,
                               input logic [7:0] idx, input logic [31:0] val, input logic [31:0] pc);
        checkVal({tag, ".en"},    32'(bus.CDB_en),        32'(en));
        checkVal({tag, ".src"},   32'(bus.CDB_src),       32'(src));
        checkVal({tag, ".idx"},   32'(bus.CDB_RoB_index), 32'(idx));
        checkVal({tag, ".value"}, bus.CDB_value,          val);
        checkVal({tag, ".pc"},    bus.CDB_next_pc,        pc);
    endtask

    task automatic checkReady(input string tag, input logic rs_rdy, input logic lsb_rdy);
        checkVal({tag, ".rs_ready"},  32'(bus.CDBRS_ready),  32'(rs_rdy));
        checkVal({tag, ".lsb_ready"}, 32'(bus.CDBLSB_ready), 32'(lsb_rdy));
    endtask

    // Directed sequence of scenarios.
    initial begin
        Sys_rst          = 1'b0;
        Sys_rdy          = 1'b1;
        RoBCDB_pre_judge = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        step();
        step();
        checkOutput("reset", 0, 0, 8'h00, 32'h0, 32'h0);
        checkReady("reset", 1, 1);
        Sys_rst = 1'b1;

        // Single RS result: no bypass, visible one edge after the push, then one cycle only.
        $display("[TB] single RS push");
        applyStimulus(1, 8'd5, 32'h1234, 32'h80, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("single.push", 0, 0, 8'h00, 32'h0, 32'h0);
        step();
        checkOutput("single.bcast", 1, 0, 8'd5, 32'h1234, 32'h80);
        step();
        checkOutput("single.idle", 0, 0, 8'd5, 32'h1234, 32'h80);

        // Fresh reset, then a tie: RS goes first, LSB next.
        $display("[TB] simultaneous push after reset");
        #2 Sys_rst = 1'b0;
        #1 Sys_rst = 1'b1;
        applyStimulus(1, 8'd1, 32'h11, 32'h44, 1, 8'd2, 32'h22);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tie.push", 0, 0, 8'h00, 32'h0, 32'h0);
        step();
        checkOutput("tie.first", 1, 0, 8'd1, 32'h11, 32'h44);
        step();
        checkOutput("tie.second", 1, 1, 8'd2, 32'h22, 32'h0);
        step();
        checkVal("tie.idle.en", 32'(bus.CDB_en), 32'h0);

        // Both producers stream 8 results each, throttled only by ready.
        $display("[TB] streaming both sources");
        rs_sent = 0; lsb_sent = 0; got = 0;
        rs_run = 0; lsb_run = 0; rs_max_run = 0; lsb_max_run = 0; rs_drops = 0; lsb_drops = 0;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            rs_go  = (rs_sent < 8) && bus.CDBRS_ready;
            lsb_go = (lsb_sent < 8) && bus.CDBLSB_ready;
            applyStimulus(rs_go, 8'(rs_sent), 32'h100 + 32'(rs_sent), 32'h2000 + 32'(4 * rs_sent),
                          lsb_go, 8'(8 + lsb_sent), 32'h300 + 32'(lsb_sent));
            step();
            if (rs_go)  rs_sent++;
            if (lsb_go) lsb_sent++;
            if (!bus.CDBRS_ready) begin
                rs_run++;
                if (rs_run == 1) rs_drops++;
                if (rs_run > rs_max_run) rs_max_run = rs_run;
            end else begin
                rs_run = 0;
            end
            if (!bus.CDBLSB_ready) begin
                lsb_run++;
                if (lsb_run == 1) lsb_drops++;
                if (lsb_run > lsb_max_run) lsb_max_run = lsb_run;
            end else begin
                lsb_run = 0;
            end
            if (bus.CDB_en) begin
                exp_src = got[0];
                exp_idx = exp_src ? 8 + got / 2 : got / 2;
                if (exp_src)
                    checkOutput($sformatf("stream[%0d]", got), 1, 1, 8'(exp_idx),
                                32'h300 + 32'(exp_idx - 8), 32'h0);
                else
                    checkOutput($sformatf("stream[%0d]", got), 1, 0, 8'(exp_idx),
                                32'h100 + 32'(exp_idx), 32'h2000 + 32'(4 * exp_idx));
                got++;
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("stream.count", 32'(got), 32'd16);
        checkVal("stream.rs_full_seen", 32'(rs_drops > 0), 32'd1);
        checkVal("stream.lsb_full_seen", 32'(lsb_drops > 0), 32'd1);
        checkVal("stream.rs_drop_len", 32'(rs_max_run), 32'd1);
        checkVal("stream.lsb_drop_len", 32'(lsb_max_run), 32'd1);
        step();
        checkVal("stream.idle.en", 32'(bus.CDB_en), 32'h0);

        // Build up a backlog, flush it, then confirm the bus works afterwards.
        $display("[TB] mispredict flush");
        applyStimulus(1, 8'h20, 32'h200, 32'h240, 1, 8'h30, 32'h300);
        step();
        checkVal("flush.fill0.en", 32'(bus.CDB_en), 32'h0);
        applyStimulus(1, 8'h21, 32'h201, 32'h244, 1, 8'h31, 32'h301);
        step();
        checkOutput("flush.fill1", 1, 0, 8'h20, 32'h200, 32'h240);
        applyStimulus(1, 8'h22, 32'h202, 32'h248, 1, 8'h32, 32'h302);
        step();
        checkOutput("flush.fill2", 1, 1, 8'h30, 32'h300, 32'h0);
        RoBCDB_pre_judge = 1'b0;
        applyStimulus(1, 8'h2F, 32'h2FF, 32'h2FC, 0, 0, 0);
        step();
        checkOutput("flush.edge", 0, 1, 8'h30, 32'h300, 32'h0);
        checkReady("flush.edge", 1, 1);
        RoBCDB_pre_judge = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        step();
        checkVal("flush.empty.en", 32'(bus.CDB_en), 32'h0);
        applyStimulus(1, 8'd9, 32'h99, 32'h990, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("flush.repush.en", 32'(bus.CDB_en), 32'h0);
        step();
        checkOutput("flush.after", 1, 0, 8'd9, 32'h99, 32'h990);
        step();
        checkVal("flush.after.idle", 32'(bus.CDB_en), 32'h0);

        // Freeze with Sys_rdy low while two RS results wait, then drain in order.
        $display("[TB] Sys_rdy hold");
        applyStimulus(1, 8'h40, 32'h400, 32'h4000, 1, 8'h41, 32'h410);
        step();
        checkVal("hold.push.en", 32'(bus.CDB_en), 32'h0);
        applyStimulus(1, 8'h42, 32'h420, 32'h4200, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("hold.first", 1, 1, 8'h41, 32'h410, 32'h0);
        Sys_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("hold.frozen[%0d]", i), 1, 1, 8'h41, 32'h410, 32'h0);
        end
        Sys_rdy = 1'b1;
        step();
        checkOutput("hold.drain0", 1, 0, 8'h40, 32'h400, 32'h4000);
        step();
        checkOutput("hold.drain1", 1, 0, 8'h42, 32'h420, 32'h4200);
        step();
        checkVal("hold.idle.en", 32'(bus.CDB_en), 32'h0);

        // Fill until the RS queue is full, then pull reset between edges.
        $display("[TB] asynchronous reset while full");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 8'(8'h50 + i), 32'h500 + 32'(i), 32'h5000, 1, 8'(8'h60 + i), 32'h600 + 32'(i));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkReady("areset.before", 0, 1);
        checkOutput("areset.before", 1, 1, 8'h62, 32'h602, 32'h0);
        #2 Sys_rst = 1'b0;
        #1;
        checkOutput("areset.during", 0, 0, 8'h00, 32'h0, 32'h0);
        checkReady("areset.during", 1, 1);
        #1 Sys_rst = 1'b1;
        step();
        checkVal("areset.after.en", 32'(bus.CDB_en), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
